// File: rtl/mac_requant.sv
// mac_requant: streams MAC accumulators through scale/round-shift/relu/zero-point/saturate
// as a three-stage handshaked pipeline framed into OUTPUT_SHAPE_1 x OUTPUT_SHAPE_2 matrices.
module mac_requant #(
    parameter int ACC_WIDTH      = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int SCALE_WIDTH    = 16,
    parameter int SHIFT_WIDTH    = 5,
    parameter int OUTPUT_SHAPE_1 = 128,
    parameter int OUTPUT_SHAPE_2 = 3072,
    parameter int RELU_EN        = 1
) (
    input  logic                          clk_p,
    input  logic                          rst_p,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [ACC_WIDTH-1:0]   in_data,
    input  logic        [SCALE_WIDTH-1:0] scale,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    input  logic signed [DATA_WIDTH-1:0]  zero_point,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic                          out_last_col,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic                          sat_flag
);
    localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;
    localparam int CW = OUTPUT_SHAPE_2 > 1 ? $clog2(OUTPUT_SHAPE_2) : 1;
    localparam int RW = OUTPUT_SHAPE_1 > 1 ? $clog2(OUTPUT_SHAPE_1) : 1;
    localparam logic signed [PW:0] QMAX = (PW+1)'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [PW:0] QMIN = -QMAX - 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t                 state;
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic                   v1, v2, lc1, lc2, l1, l2;
    logic signed [PW-1:0]   p1, prod;
    logic signed [PW:0]     r2, rnd, rsh, relu, q;
    logic        [PW:0]     half;
    logic signed [DATA_WIDTH-1:0] qs;
    logic                   advance, acc, at_lc, at_l, clamp;
    assign advance  = !out_valid || out_ready;
    assign in_ready = (state == RUN) && advance;
    assign busy     = state != IDLE;
    assign acc      = in_valid && in_ready;
    assign at_lc    = col == CW'(OUTPUT_SHAPE_2 - 1);
    assign at_l     = at_lc && row == RW'(OUTPUT_SHAPE_1 - 1);
    // scale is unsigned, so it is zero-extended into the signed product
    always_comb begin
        prod  = in_data * $signed({1'b0, scale});
        half  = (shift == '0) ? '0 : (PW+1)'(1) << (shift - 1'b1);
        rnd   = p1 + $signed(half);
        rsh   = rnd >>> shift;
        relu  = (RELU_EN != 0 && r2 < 0) ? '0 : r2;
        q     = relu + zero_point;
        clamp = q > QMAX || q < QMIN;
        qs    = q > QMAX ? QMAX[DATA_WIDTH-1:0] : q < QMIN ? QMIN[DATA_WIDTH-1:0] : q[DATA_WIDTH-1:0];
    end
    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            {v1, v2, lc1, lc2, l1, l2} <= '0;
            p1           <= '0;
            r2           <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last_col <= 1'b0;
            out_last     <= 1'b0;
            done         <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                state    <= RUN;
                col      <= '0;
                row      <= '0;
                sat_flag <= 1'b0;
            end
            if (acc) begin
                col <= at_lc ? '0 : col + 1'b1;
                if (at_lc) row <= at_l ? '0 : row + 1'b1;
                if (at_l) state <= DRAIN;
            end
            if (state == DRAIN && out_valid && out_ready && out_last) begin
                state <= IDLE;
                done  <= 1'b1;
            end
            // every stage moves together, so empty slots travel as bubbles
            if (advance) begin
                v1           <= acc;
                p1           <= prod;
                lc1          <= at_lc;
                l1           <= at_l;
                v2           <= v1;
                r2           <= rsh;
                lc2          <= lc1;
                l2           <= l1;
                out_valid    <= v2;
                out_data     <= qs;
                out_last_col <= lc2;
                out_last     <= l2;
                if (v2 && clamp) sat_flag <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mac_requant.sv
// tb_mac_requant: scoreboard bench driving a relu-off and a relu-on instance with shared
// directed 2x3 matrices and comparing against hand-computed results.
module tb_mac_requant;
    logic clk_p = 1'b0, rst_p = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic signed [31:0] in_data = '0;
    logic [15:0] scale = '0;
    logic [4:0]  shift = '0;
    logic signed [7:0] zero_point = '0;
    logic in_ready [2], out_valid [2], out_last_col [2], out_last [2], busy [2], done [2], sat_flag [2];
    logic signed [7:0] out_data [2];
    for (genvar g = 0; g < 2; g++) begin : du
        mac_requant #(.OUTPUT_SHAPE_1(2), .OUTPUT_SHAPE_2(3), .RELU_EN(g)) dut (
            .clk_p(clk_p), .rst_p(rst_p), .start(start), .in_valid(in_valid),
            .in_ready(in_ready[g]), .in_data(in_data), .scale(scale), .shift(shift),
            .zero_point(zero_point), .out_valid(out_valid[g]), .out_ready(out_ready),
            .out_data(out_data[g]), .out_last_col(out_last_col[g]), .out_last(out_last[g]),
            .busy(busy[g]), .done(done[g]), .sat_flag(sat_flag[g]));
    end
    always #5 clk_p = ~clk_p;
    int cyc = 0;
    always @(posedge clk_p) cyc <= cyc + 1;
    typedef struct {int d; bit lc; bit l; int t; bit lat;} exp_t;
    exp_t q0[$], q1[$];
    int total = 0, bad = 0;
    bit pend [2] = '{0, 0};
    int vin [4][6] = '{'{10, -6, 0, 1, 2, 100}, '{-6, 7, -2, -3, 6, 5},
                       '{300, -5, -300, 127, 128, -128}, '{5, -4, 0, 70, 100, -70}};
    int ve [2][4][6] = '{
        '{'{8, -4, 0, 1, 2, 75}, '{-1, 2, 0, -1, 2, 1}, '{127, -5, -128, 127, 127, -128}, '{2, -7, -3, 67, 97, -73}},
        '{'{8, 0, 0, 1, 2, 75}, '{0, 2, 0, 0, 2, 1}, '{127, 0, 0, 127, 127, 0}, '{2, -3, -3, 67, 97, -3}}};
    int cfg [4][3] = '{'{3, 2, 0}, '{1, 2, 0}, '{1, 0, 0}, '{2, 1, -3}};
    int vsat [2][4] = '{'{0, 0, 1, 0}, '{0, 0, 1, 0}};

    task automatic chk(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    always @(negedge clk_p) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            if (pend[k]) begin
                chk($sformatf("done%0d", k), int'(done[k]), 1);
                pend[k] = 0;
            end
            if (out_valid[k] === 1'b1 && out_ready) begin
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stray%0d: got beat %0d expected none", k, out_data[k]);
                end else begin
                    if (k == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    chk($sformatf("data%0d", k), int'(out_data[k]), e.d);
                    chk($sformatf("last_col%0d", k), int'(out_last_col[k]), int'(e.lc));
                    chk($sformatf("last%0d", k), int'(out_last[k]), int'(e.l));
                    if (e.lat) chk($sformatf("latency%0d", k), cyc - e.t, 3);
                    if (out_last[k]) pend[k] = 1;
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_p);
        #1 start = 1'b0;
    endtask

    task automatic send(input int m, input int i, input bit lat);
        int n = 0;
        in_data  = vin[m][i];
        in_valid = 1'b1;
        @(negedge clk_p);
        while (!in_ready[0] && n < 100) begin
            n++;
            @(negedge clk_p);
        end
        if (!in_ready[0]) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        q0.push_back('{ve[0][m][i], i % 3 == 2, i == 5, cyc, lat});
        q1.push_back('{ve[1][m][i], i % 3 == 2, i == 5, cyc, lat});
        @(posedge clk_p);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done[0] && n < 60) begin
            @(negedge clk_p);
            n++;
        end
        if (!done[0]) chk("done_timeout", 0, 1);
    endtask

    task automatic check_idle_zero(input string nm);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s%0d", nm, k), int'({out_valid[k], out_last_col[k], out_last[k], busy[k],
                done[k], in_ready[k], sat_flag[k], out_data[k]}), 0);
    endtask

    task automatic run_mat(input int m, input bit lat, input bit stall, input bit midstart);
        scale      = 16'(cfg[m][0]);
        shift      = 5'(cfg[m][1]);
        zero_point = 8'(cfg[m][2]);
        pulse_start();
        chk("busy_run", int'(busy[0]), 1);
        for (int i = 0; i < 6; i++) begin
            send(m, i, lat);
            if (stall && i == 2) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk_p);
                    for (int k = 0; k < 2; k++) begin
                        chk($sformatf("stall_valid%0d", k), int'(out_valid[k]), 1);
                        chk($sformatf("stall_data%0d", k), int'(out_data[k]), ve[k][m][0]);
                        chk($sformatf("stall_in_ready%0d", k), int'(in_ready[k]), 0);
                    end
                end
                @(posedge clk_p);
                #1 out_ready = 1'b1;
            end
            if (midstart && i == 3) begin
                pulse_start();
                for (int k = 0; k < 2; k++) chk($sformatf("sat_midstart%0d", k), int'(sat_flag[k]), 1);
            end
        end
        chk("in_ready_after_last", int'(in_ready[0]), 0);
        wait_done();
        chk("busy_after_done", int'(busy[0]), 0);
        chk("queue0_empty", q0.size(), 0);
        chk("queue1_empty", q1.size(), 0);
        for (int k = 0; k < 2; k++) chk($sformatf("sat_end%0d_m%0d", k, m), int'(sat_flag[k]), vsat[k][m]);
    endtask

    initial begin
        repeat (2) @(posedge clk_p);
        #1 rst_p = 1'b0;
        @(negedge clk_p);
        check_idle_zero("reset_state");
        in_valid = 1'b1;
        in_data  = 32'sd5;
        repeat (3) begin
            @(negedge clk_p);
            chk("idle_in_ready", int'(in_ready[0]), 0);
        end
        @(posedge clk_p);
        #1 in_valid = 1'b0;
        run_mat(0, 1'b1, 1'b0, 1'b0);
        run_mat(1, 1'b1, 1'b0, 1'b0);
        run_mat(2, 1'b1, 1'b0, 1'b1);
        run_mat(3, 1'b0, 1'b1, 1'b0);
        scale      = 16'd3;
        shift      = 5'd2;
        zero_point = 8'sd0;
        pulse_start();
        send(0, 0, 1'b0);
        send(0, 1, 1'b0);
        rst_p = 1'b1;
        @(posedge clk_p);
        #1 rst_p = 1'b0;
        q0.delete();
        q1.delete();
        pend = '{0, 0};
        @(negedge clk_p);
        check_idle_zero("midrun_reset");
        run_mat(0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk_p);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/mac_requant.md
MAC_REQUANT -- requirements
Module: mac_requant

Interface (parameters: name, default, meaning)
REQ-001 SHALL: ACC_WIDTH, 32, signed width of each incoming MAC accumulator element.
REQ-002 SHALL: DATA_WIDTH, 8, signed width of each requantized output element.
REQ-003 SHALL: SCALE_WIDTH, 16, unsigned requant multiplier width.
REQ-004 SHALL: SHIFT_WIDTH, 5, right-shift amount width.
REQ-005 SHALL: OUTPUT_SHAPE_1, 128, rows per matrix; OUTPUT_SHAPE_2, 3072, columns per row.
REQ-006 SHALL: RELU_EN, 1, 1 = clamp negative values to 0 before zero-point add.

Interface (ports: name direction width meaning)
REQ-007 SHALL: clk_p in 1 single clock; all logic on its rising edge.
REQ-008 SHALL: rst_p in 1 reset, synchronous, active-high.
REQ-009 SHALL: start in 1 one-cycle request to begin a matrix.
REQ-010 SHALL: in_valid in 1 / in_ready out 1 / in_data in ACC_WIDTH: row-major element stream from the MAC stage.
REQ-011 SHALL: scale in SCALE_WIDTH, shift in SHIFT_WIDTH, zero_point in DATA_WIDTH (signed); held stable from start until done.
REQ-012 SHALL: out_valid out 1 / out_ready in 1 / out_data out DATA_WIDTH: requantized stream.
REQ-013 SHALL: out_last_col out 1 (last element of a row), out_last out 1 (last element of the matrix), qualified by out_valid.
REQ-014 SHALL: busy out 1, done out 1 (one-cycle pulse), sat_flag out 1 (sticky saturation indicator).

Function
REQ-015 SHALL: FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when element OUTPUT_SHAPE_1*OUTPUT_SHAPE_2-1 is accepted; DRAIN->IDLE when the out_last beat transfers.
REQ-016 SHALL: start in RUN or DRAIN is ignored; start in IDLE clears column/row counters and sat_flag.
REQ-017 SHALL: in_ready = (state==RUN) AND advance, where advance = NOT out_valid OR out_ready; input transfers when in_valid AND in_ready.
REQ-018 SHALL: three-stage pipeline, all stages enabled by advance; stage valids shift in lockstep; bubbles are not collapsed.
REQ-019 SHALL: stage 1: p = in_data * scale, signed result ACC_WIDTH+SCALE_WIDTH+1 bits, no truncation.
REQ-020 SHALL: stage 2: if shift>0, r = (p + 2^(shift-1)) >>> shift (arithmetic, round half toward +inf); if shift==0, r = p.
REQ-021 SHALL: stage 3: if RELU_EN and r<0 then r=0; q = r + zero_point; saturate q to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-022 SHALL: sat_flag set on any output beat whose q was clamped; holds until reset or accepted start.
REQ-023 SHALL: latency: accepted input appears on out_data exactly 3 cycles later when out_ready stays high.
REQ-024 SHALL: column counter wraps 0..OUTPUT_SHAPE_2-1, row counter increments on wrap; last-col/last flags computed at acceptance and carried with the data.
REQ-025 SHALL: out_valid held with out_data stable while out_ready low; no beat dropped or duplicated.
REQ-026 SHALL: done pulses the cycle after the out_last transfer; busy = (state != IDLE).
REQ-027 SHALL: in IDLE, in_valid is ignored and in_ready is 0.

Reset
REQ-028 SHALL: rst_p high for one clock edge returns state to IDLE, clears all pipeline valids, counters, sat_flag; out_valid, out_data, out_last_col, out_last, busy, done, in_ready all 0.
REQ-029 SHALL: rst_p asserted mid-RUN or mid-DRAIN discards all in-flight data; no out_valid on the cycle after reset.

Verification
REQ-030 SHALL: scale=3, shift=2, zp=0, in_data=10 -> out_data=8 after 3 cycles; in_data=-6, scale=1, shift=2, RELU_EN=0 -> -1.
REQ-031 SHALL: scale=1, shift=0, zp=0, in_data=300 -> 127 and sat_flag=1; in_data=-5 with RELU_EN=1 -> 0, sat_flag unchanged.
REQ-032 SHALL: OUTPUT_SHAPE_1=2, OUTPUT_SHAPE_2=3, 6 beats -> out_last_col on beats 3 and 6, out_last on beat 6, done one cycle later, in_ready low after beat 6 accepted.
REQ-033 SHALL: out_ready low 5 cycles mid-stream -> out_data constant, in_ready low, output sequence identical to no-stall run.
REQ-034 SHALL: rst_p pulsed with 2 beats in flight -> all outputs 0 next cycle, no stale beat after subsequent start.
REQ-035 SHALL: start pulsed during RUN -> counters and sat_flag unchanged, stream completes normally.
